// File: rtl/data_mem_arbiter.sv
`default_nettype none
// data_mem_arbiter: shares one single-ported data memory between requester A (CPU) and B (DMA).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on contention; default build gives A fixed priority.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              AReq,
  input  logic              AWe,
  input  logic [ADDR_W-1:0] AAddr,
  input  logic [DATA_W-1:0] AWData,
  output logic              AAck,
  output logic [DATA_W-1:0] ARData,
  input  logic              BReq,
  input  logic              BWe,
  input  logic [ADDR_W-1:0] BAddr,
  input  logic [DATA_W-1:0] BWData,
  output logic              BAck,
  output logic [DATA_W-1:0] BRData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWriteEnable,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              Busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t              state_q;
  logic                grant_b_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mwe_q;
  logic                ack_a_q;
  logic                ack_b_q;
  logic                busy_q;
  logic [DATA_W-1:0]   rdata_a_q;
  logic [DATA_W-1:0]   rdata_b_q;
  logic                pick_b;
  logic                any_req;

  assign any_req = AReq | BReq;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_b_q;

  // On contention, B wins only if A was granted last.
  assign pick_b = BReq & (~AReq | ~last_b_q);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_b_q <= 1'b1;
    end else if (state_q == ST_IDLE && any_req) begin
      last_b_q <= pick_b;
    end
  end
`else
  assign pick_b = BReq & ~AReq;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      grant_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mwe_q     <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_b_q <= pick_b;
            we_q      <= pick_b ? BWe    : AWe;
            addr_q    <= pick_b ? BAddr  : AAddr;
            wdata_q   <= pick_b ? BWData : AWData;
            mwe_q     <= pick_b ? BWe    : AWe;
            busy_q    <= 1'b1;
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mwe_q   <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // The memory registered the read data at the ACCESS->WAIT edge.
          if (!we_q) begin
            if (grant_b_q) rdata_b_q <= MemReadData;
            else           rdata_a_q <= MemReadData;
          end
          ack_a_q <= ~grant_b_q;
          ack_b_q <= grant_b_q;
          state_q <= ST_ACK;
        end
        default: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MemAddress     = addr_q;
  assign MemWriteData   = wdata_q;
  assign MemWriteEnable = mwe_q;
  assign AAck           = ack_a_q;
  assign BAck           = ack_b_q;
  assign ARData         = rdata_a_q;
  assign BRData         = rdata_b_q;
  assign Busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// tb_data_mem_arbiter: directed self-checking bench with a behavioural single-port memory.
module tb_data_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        AReq, AWe, BReq, BWe;
  logic [31:0] AAddr, BAddr, AWData, BWData;
  logic        AAck, BAck;
  logic [31:0] ARData, BRData;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic        MemWriteEnable, Busy;

  logic [31:0] mem [0:15];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 Clock = ~Clock;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .AReq(AReq), .AWe(AWe), .AAddr(AAddr), .AWData(AWData), .AAck(AAck), .ARData(ARData),
    .BReq(BReq), .BWe(BWe), .BAddr(BAddr), .BWData(BWData), .BAck(BAck), .BRData(BRData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWriteEnable(MemWriteEnable),
    .MemReadData(MemReadData), .Busy(Busy)
  );

  always @(posedge Clock) begin
    if (MemWriteEnable) mem[MemAddress[3:0]] <= MemWriteData;
    else                MemReadData <= mem[MemAddress[3:0]];
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    AReq = 0; AWe = 0; AAddr = 0; AWData = 0;
    BReq = 0; BWe = 0; BAddr = 0; BWData = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    step(); step();
    tests_run++;
    if ({AAck, BAck, MemWriteEnable, Busy} !== 4'b0 || ARData !== 0 || BRData !== 0 ||
        MemAddress !== 0 || MemWriteData !== 0) begin
      tests_failed++;
      $display("FAIL reset_state: ack=%b%b we=%b busy=%b ard=%h brd=%h addr=%h wd=%h, required all 0",
               AAck, BAck, MemWriteEnable, Busy, ARData, BRData, MemAddress, MemWriteData);
    end
    Reset = 1'b0;
    step();
    tests_run++;
    if (Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: Busy=%b required 0", Busy);
    end
  endtask

  task automatic test_read();
    mem[5] = 32'hDEADBEEF;
    AReq = 1; AWe = 0; AAddr = 5;
    step();
    AReq = 0;
    tests_run++;
    if (Busy !== 1 || MemWriteEnable !== 0 || MemAddress !== 32'd5 || AAck !== 0) begin
      tests_failed++;
      $display("FAIL read_access: busy=%b we=%b addr=%h aack=%b required 1 0 5 0",
               Busy, MemWriteEnable, MemAddress, AAck);
    end
    step();
    tests_run++;
    if (AAck !== 0 || MemWriteEnable !== 0) begin
      tests_failed++;
      $display("FAIL read_wait: aack=%b we=%b required 0 0", AAck, MemWriteEnable);
    end
    step();
    tests_run++;
    if (AAck !== 1 || BAck !== 0 || ARData !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL read_ack: aack=%b back=%b ardata=%h required 1 0 deadbeef", AAck, BAck, ARData);
    end
    step();
    tests_run++;
    if (AAck !== 0 || Busy !== 0) begin
      tests_failed++;
      $display("FAIL read_idle: aack=%b busy=%b required 0 0", AAck, Busy);
    end
  endtask

  task automatic test_write_read();
    int we_cycles;
    BReq = 1; BWe = 1; BAddr = 9; BWData = 32'h12345678;
    step();
    BReq = 0;
    tests_run++;
    if (MemWriteEnable !== 1 || MemAddress !== 32'd9 || MemWriteData !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL write_access: we=%b addr=%h wd=%h required 1 9 12345678",
               MemWriteEnable, MemAddress, MemWriteData);
    end
    we_cycles = 1;
    step(); if (MemWriteEnable === 1'b1) we_cycles++;
    step(); if (MemWriteEnable === 1'b1) we_cycles++;
    tests_run++;
    if (BAck !== 1 || AAck !== 0 || we_cycles != 1) begin
      tests_failed++;
      $display("FAIL write_ack: back=%b aack=%b we_cycles=%0d required 1 0 1", BAck, AAck, we_cycles);
    end
    step();
    tests_run++;
    if (mem[9] !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL write_mem: mem[9]=%h required 12345678", mem[9]);
    end
    BReq = 1; BWe = 0; BAddr = 9; BWData = 32'h0;
    step();
    BReq = 0;
    step(); step();
    tests_run++;
    if (BAck !== 1 || BRData !== 32'h12345678 || ARData !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL write_readback: back=%b brdata=%h ardata=%h required 1 12345678 deadbeef",
               BAck, BRData, ARData);
    end
    step();
  endtask

  task automatic test_contention();
    logic [3:0] exp_b;
    int waited;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_b = 4'b1010;
`else
    exp_b = 4'b0000;
`endif
    mem[1] = 32'h11111111; mem[2] = 32'h22222222;
    AWe = 0; BWe = 0; AAddr = 1; BAddr = 2;
    AReq = 1; BReq = 1;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (!(AAck === 1'b1 || BAck === 1'b1) && waited < 8) begin
        step();
        waited++;
      end
      tests_run++;
      if (waited >= 8) begin
        tests_failed++;
        $display("FAIL contention_timeout: grant %0d no ack within 8 cycles", g);
      end else if (BAck !== exp_b[g] || AAck !== ~exp_b[g]) begin
        tests_failed++;
        $display("FAIL contention_order: grant %0d aack=%b back=%b required %b %b",
                 g, AAck, BAck, ~exp_b[g], exp_b[g]);
      end
      step();
    end
    AReq = 0; BReq = 0;
    step();
  endtask

  task automatic test_stability();
    mem[7] = 32'h77777777;
    AReq = 1; AWe = 0; AAddr = 5;
    step();
    AReq = 0; AAddr = 7;
    tests_run++;
    if (MemAddress !== 32'd5) begin
      tests_failed++;
      $display("FAIL stability_addr: MemAddress=%h required 5", MemAddress);
    end
    step(); step();
    tests_run++;
    if (AAck !== 1 || ARData !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL stability_data: aack=%b ardata=%h required 1 deadbeef", AAck, ARData);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int back_seen;
    mem[3] = 32'h33333333;
    BReq = 1; BWe = 1; BAddr = 3; BWData = 32'h00000BAD;
    step();
    BReq = 0;
    Reset = 1'b1;
    #1;
    tests_run++;
    if ({AAck, BAck, MemWriteEnable, Busy} !== 4'b0 || ARData !== 0 || BRData !== 0 ||
        MemAddress !== 0 || MemWriteData !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: ack=%b%b we=%b busy=%b ard=%h brd=%h addr=%h wd=%h, required all 0",
               AAck, BAck, MemWriteEnable, Busy, ARData, BRData, MemAddress, MemWriteData);
    end
    step();
    Reset = 1'b0;
    back_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (BAck === 1'b1 || Busy === 1'b1) back_seen++;
    end
    tests_run++;
    if (back_seen != 0 || mem[3] !== 32'h33333333) begin
      tests_failed++;
      $display("FAIL reset_mid_discard: ack_or_busy_cycles=%0d mem[3]=%h required 0 33333333",
               back_seen, mem[3]);
    end
  endtask

  task automatic test_back_to_back();
    AReq = 1; AWe = 0; AAddr = 5;
    for (int k = 1; k <= 16; k++) begin
      step();
      tests_run++;
      if (AAck !== ((k % 4) == 3) || Busy !== ((k % 4) != 0) || BAck !== 1'b0) begin
        tests_failed++;
        $display("FAIL back_to_back: cycle %0d aack=%b busy=%b back=%b required %b %b 0",
                 k, AAck, Busy, BAck, ((k % 4) == 3), ((k % 4) != 0));
      end
    end
    AReq = 0;
    step(); step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_stability();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
